// File: rtl/regfile_wb_arbiter.sv
// Register scoreboard plus round-robin arbiter for the single regfile write port.
// Issue stalls on RAW/WAW; granted writes reach the regfile through a registered stage.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 64,
    parameter int REG_AW   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iss_valid,
    input  logic                iss_we,
    input  logic [REG_AW-1:0]   iss_dst,
    input  logic [REG_AW-1:0]   iss_src1,
    input  logic [REG_AW-1:0]   iss_src2,
    output logic                iss_ready,
    input  logic                wb0_valid,
    input  logic [REG_AW-1:0]   wb0_reg,
    input  logic [DATA_W-1:0]   wb0_data,
    output logic                wb0_ready,
    input  logic                wb1_valid,
    input  logic [REG_AW-1:0]   wb1_reg,
    input  logic [DATA_W-1:0]   wb1_data,
    output logic                wb1_ready,
    output logic                RegWrite,
    output logic [REG_AW-1:0]   WriteRegister,
    output logic [DATA_W-1:0]   WriteData,
    output logic [NUM_REGS-1:0] busy,
    output logic                err_wb_unbusy
);

    localparam logic [REG_AW-1:0] XZR = REG_AW'(NUM_REGS - 1);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                pref_q, pref_d;
    logic                regwrite_q, regwrite_d;
    logic [REG_AW-1:0]   wreg_q, wreg_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;

    logic                iss_fire;
    logic                wb0_gnt, wb1_gnt, gnt;
    logic [REG_AW-1:0]   gnt_reg;
    logic [DATA_W-1:0]   gnt_data;

    always_comb begin
        iss_ready = !reset
                 && !busy_q[iss_src1]
                 && !busy_q[iss_src2]
                 && !(iss_we && busy_q[iss_dst]);
        wb0_ready = !reset && (!pref_q || !wb1_valid);
        wb1_ready = !reset && (pref_q || !wb0_valid);
    end

    assign iss_fire = iss_valid && iss_ready;
    assign wb0_gnt  = wb0_valid && wb0_ready;
    assign wb1_gnt  = wb1_valid && wb1_ready;
    assign gnt      = wb0_gnt || wb1_gnt;
    assign gnt_reg  = wb1_gnt ? wb1_reg : wb0_reg;
    assign gnt_data = wb1_gnt ? wb1_data : wb0_data;

    always_comb begin
        busy_d     = busy_q;
        pref_d     = pref_q;
        regwrite_d = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        err_d      = err_q;

        // Clear first so a same-edge set on the same register wins.
        if (regwrite_q)
            busy_d[wreg_q] = 1'b0;
        if (iss_fire && iss_we && iss_dst != XZR)
            busy_d[iss_dst] = 1'b1;
        busy_d[NUM_REGS-1] = 1'b0;

        if (wb0_valid && wb1_valid && gnt)
            pref_d = wb0_gnt;

        if (gnt) begin
            regwrite_d = (gnt_reg != XZR);
            wreg_d     = gnt_reg;
            wdata_d    = gnt_data;
            if (gnt_reg != XZR && !busy_q[gnt_reg])
                err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q     <= '0;
            pref_q     <= 1'b0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            pref_q     <= pref_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

    assign RegWrite      = regwrite_q;
    assign WriteRegister = wreg_q;
    assign WriteData     = wdata_q;
    assign busy          = busy_q;
    assign err_wb_unbusy = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: scoreboard, arbitration, XZR, error flag, reset.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        iss_valid, iss_we;
    logic [4:0]  iss_dst, iss_src1, iss_src2;
    logic        iss_ready;
    logic        wb0_valid, wb1_valid;
    logic [4:0]  wb0_reg, wb1_reg;
    logic [63:0] wb0_data, wb1_data;
    logic        wb0_ready, wb1_ready;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [31:0] busy;
    logic        err_wb_unbusy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .iss_valid     (iss_valid),
        .iss_we        (iss_we),
        .iss_dst       (iss_dst),
        .iss_src1      (iss_src1),
        .iss_src2      (iss_src2),
        .iss_ready     (iss_ready),
        .wb0_valid     (wb0_valid),
        .wb0_reg       (wb0_reg),
        .wb0_data      (wb0_data),
        .wb0_ready     (wb0_ready),
        .wb1_valid     (wb1_valid),
        .wb1_reg       (wb1_reg),
        .wb1_data      (wb1_data),
        .wb1_ready     (wb1_ready),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .busy          (busy),
        .err_wb_unbusy (err_wb_unbusy)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] dst);
        iss_valid = 1'b1;
        iss_we    = 1'b1;
        iss_dst   = dst;
        iss_src1  = 5'd0;
        iss_src2  = 5'd0;
        tick();
        iss_valid = 1'b0;
        iss_we    = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        iss_valid = 1'b1;
        iss_we    = 1'b1;
        iss_dst   = 5'd1;
        iss_src1  = 5'd0;
        iss_src2  = 5'd0;
        wb0_valid = 1'b1;
        wb0_reg   = 5'd1;
        wb0_data  = 64'h11;
        wb1_valid = 1'b1;
        wb1_reg   = 5'd2;
        wb1_data  = 64'h22;

        // 1: reset with everything requesting
        tick();
        tick();
        chk("rst_iss_ready", 64'(iss_ready), 64'd0);
        chk("rst_wb0_ready", 64'(wb0_ready), 64'd0);
        chk("rst_wb1_ready", 64'(wb1_ready), 64'd0);
        chk("rst_regwrite", 64'(RegWrite), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_wb_unbusy), 64'd0);
        chk("rst_wreg", 64'(WriteRegister), 64'd0);
        chk("rst_wdata", WriteData, 64'd0);
        iss_valid = 1'b0;
        iss_we    = 1'b0;
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        reset     = 1'b0;
        #1;
        chk("post_rst_iss_ready", 64'(iss_ready), 64'd1);

        // 2: RAW stall and release via wb0
        issue(5'd3);
        chk("t2_busy3", 64'(busy), 64'h8);
        iss_src1 = 5'd3;
        #1;
        chk("t2_raw_stall", 64'(iss_ready), 64'd0);
        wb0_valid = 1'b1;
        wb0_reg   = 5'd3;
        wb0_data  = 64'h0000010204080001;
        #1;
        chk("t2_wb0_ready", 64'(wb0_ready), 64'd1);
        tick();
        wb0_valid = 1'b0;
        chk("t2_regwrite", 64'(RegWrite), 64'd1);
        chk("t2_wreg", 64'(WriteRegister), 64'd3);
        chk("t2_wdata", WriteData, 64'h0000010204080001);
        chk("t2_busy_held", 64'(busy), 64'h8);
        chk("t2_still_stall", 64'(iss_ready), 64'd0);
        tick();
        chk("t2_regwrite_off", 64'(RegWrite), 64'd0);
        chk("t2_busy_clr", 64'(busy), 64'd0);
        chk("t2_ready", 64'(iss_ready), 64'd1);
        chk("t2_err", 64'(err_wb_unbusy), 64'd0);
        iss_src1 = 5'd0;

        // 3: simultaneous requests, round robin
        issue(5'd5);
        issue(5'd6);
        chk("t3_busy", 64'(busy), 64'h60);
        iss_we  = 1'b1;
        iss_dst = 5'd5;
        #1;
        chk("t3_waw_stall", 64'(iss_ready), 64'd0);
        iss_we    = 1'b0;
        wb0_valid = 1'b1;
        wb0_reg   = 5'd5;
        wb0_data  = 64'h55;
        wb1_valid = 1'b1;
        wb1_reg   = 5'd6;
        wb1_data  = 64'h66;
        #1;
        chk("t3_wb0_first", 64'(wb0_ready), 64'd1);
        chk("t3_wb1_wait", 64'(wb1_ready), 64'd0);
        tick();
        wb0_valid = 1'b0;
        chk("t3_rw5", 64'(RegWrite), 64'd1);
        chk("t3_wreg5", 64'(WriteRegister), 64'd5);
        chk("t3_wdata5", WriteData, 64'h55);
        #1;
        chk("t3_wb1_second", 64'(wb1_ready), 64'd1);
        tick();
        wb1_valid = 1'b0;
        chk("t3_rw6", 64'(RegWrite), 64'd1);
        chk("t3_wreg6", 64'(WriteRegister), 64'd6);
        chk("t3_wdata6", WriteData, 64'h66);
        chk("t3_busy_mid", 64'(busy), 64'h40);
        tick();
        chk("t3_rw_off", 64'(RegWrite), 64'd0);
        chk("t3_busy_clr", 64'(busy), 64'd0);

        // 4: XZR destination and write
        issue(5'd31);
        chk("t4_busy_xzr", 64'(busy), 64'd0);
        wb1_valid = 1'b1;
        wb1_reg   = 5'd31;
        wb1_data  = 64'hdead;
        #1;
        chk("t4_wb1_ready", 64'(wb1_ready), 64'd1);
        tick();
        wb1_valid = 1'b0;
        chk("t4_rw_xzr", 64'(RegWrite), 64'd0);
        chk("t4_err", 64'(err_wb_unbusy), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);

        // 5: write to a register that is not busy
        wb1_valid = 1'b1;
        wb1_reg   = 5'd7;
        wb1_data  = 64'h77;
        tick();
        wb1_valid = 1'b0;
        chk("t5_err_set", 64'(err_wb_unbusy), 64'd1);
        chk("t5_rw", 64'(RegWrite), 64'd1);
        chk("t5_wreg", 64'(WriteRegister), 64'd7);
        tick();
        chk("t5_err_sticky", 64'(err_wb_unbusy), 64'd1);
        chk("t5_rw_off", 64'(RegWrite), 64'd0);

        // 6: reset mid-operation; pref is wb1 at this point
        issue(5'd3);
        issue(5'd4);
        chk("t6_busy", 64'(busy), 64'h18);
        wb0_valid = 1'b1;
        wb0_reg   = 5'd3;
        wb0_data  = 64'h33;
        wb1_valid = 1'b1;
        wb1_reg   = 5'd4;
        wb1_data  = 64'h44;
        #1;
        chk("t6_pref_wb1", 64'(wb1_ready), 64'd1);
        chk("t6_wb0_wait", 64'(wb0_ready), 64'd0);
        reset = 1'b1;
        #1;
        chk("t6_rst_wb0_ready", 64'(wb0_ready), 64'd0);
        chk("t6_rst_wb1_ready", 64'(wb1_ready), 64'd0);
        tick();
        reset = 1'b0;
        chk("t6_busy_clr", 64'(busy), 64'd0);
        chk("t6_rw", 64'(RegWrite), 64'd0);
        chk("t6_err_clr", 64'(err_wb_unbusy), 64'd0);
        #1;
        chk("t6_pref_wb0", 64'(wb0_ready), 64'd1);
        chk("t6_pref_wb1_off", 64'(wb1_ready), 64'd0);
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        tick();
        chk("t6_idle_rw", 64'(RegWrite), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
